// File: rtl/seq_mult8.sv
// Sequential unsigned 8x8->16 shift-and-add multiplier.
// One partial product per cycle is accumulated through a 16-bit CLA.

module bit16adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c0,
  output logic [15:0] sum,
  output logic        c16
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  // Two-level lookahead: 4-bit groups, then group carries.
  always_comb begin
    gg = '0;
    gp = '0;
    for (int i = 0; i < 4; i++) begin
      gg[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      gp[i] = &p[4*i +: 4];
    end
  end

  always_comb begin
    gc    = '0;
    gc[0] = c0;
    gc[1] = gg[0] | (gp[0] & c0);
    gc[2] = gg[1] | (gp[1] & gg[0])
          | (gp[1] & gp[0] & c0);
    gc[3] = gg[2] | (gp[2] & gg[1])
          | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & c0);
    gc[4] = gg[3] | (gp[3] & gg[2])
          | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & c0);
  end

  always_comb begin
    c = '0;
    for (int i = 0; i < 4; i++) begin
      c[4*i]   = gc[i];
      c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
      c[4*i+2] = g[4*i+1]
               | (p[4*i+1] & g[4*i])
               | (p[4*i+1] & p[4*i] & gc[i]);
      c[4*i+3] = g[4*i+2]
               | (p[4*i+2] & g[4*i+1])
               | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
    end
  end

  assign sum = p ^ c;
  assign c16 = gc[4];

endmodule

module seq_mult8 #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q;
  state_e      state_d;
  logic [15:0] mcand_q;
  logic [15:0] mcand_d;
  logic [7:0]  mplier_q;
  logic [7:0]  mplier_d;
  logic [15:0] acc_q;
  logic [15:0] acc_d;
  logic [2:0]  count_q;
  logic [2:0]  count_d;

  logic [15:0] pp;
  logic [15:0] sum;
  logic        add_co_unused;
  logic        accept;
  logic        running;
  logic        last;

  assign accept  = (state_q == IDLE) && in_valid;
  assign running = (state_q == RUN);
  assign pp      = mplier_q[0] ? mcand_q : 16'h0000;

  // Product fits in 16 bits, so the carry-out never matters.
  bit16adder u_add (
    .a   (acc_q),
    .b   (pp),
    .c0  (1'b0),
    .sum (sum),
    .c16 (add_co_unused)
  );

  always_comb begin
    last = (count_q == 3'd7);
    if (EARLY_EXIT) begin
      last = last || (mplier_q[7:1] == 7'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    product   = acc_q;
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    unique case (1'b1)
      accept: begin
        mcand_d  = {8'h00, a};
        mplier_d = b;
        acc_d    = 16'h0000;
        count_d  = 3'd0;
      end
      running: begin
        mcand_d  = {mcand_q[14:0], 1'b0};
        mplier_d = {1'b0, mplier_q[7:1]};
        acc_d    = sum;
        count_d  = count_q + 3'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_seq_mult8.sv
// Bench for seq_mult8: one instance per EARLY_EXIT setting,
// directed table, corner sequences and random ops vs a*b model.

module tb_seq_mult8;

  logic             clk;
  logic             rst_n;
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;
  logic [1:0][7:0]  a_s;
  logic [1:0][7:0]  b_s;
  logic [1:0][15:0] prod;

  int n_vec;
  int n_err;

  seq_mult8 #(.EARLY_EXIT(1'b0)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .a         (a_s[0]),
    .b         (b_s[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .product   (prod[0])
  );

  seq_mult8 #(.EARLY_EXIT(1'b1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .a         (a_s[1]),
    .b         (b_s[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .product   (prod[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: product is a*b; RUN cycles are 8, or the
  // bit length of b (min 1) when iteration exits early.
  function automatic int run_cycles(input int d,
                                    input logic [7:0] bv);
    int r;
    r = 1;
    if (d == 0) return 8;
    for (int i = 0; i < 8; i++)
      if (bv[i]) r = i + 1;
    return r;
  endfunction

  task automatic run_op(input int d,
                        input logic [7:0] av,
                        input logic [7:0] bv,
                        input int hold,
                        input bit rnd);
    int n;
    logic [15:0] ep;
    int ecyc;
    ep   = 16'(av) * 16'(bv);
    ecyc = run_cycles(d, bv);
    @(negedge clk);
    in_valid[d] = 1'b1;
    a_s[d] = av;
    b_s[d] = bv;
    n = 0;
    while (!in_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[d]) begin
      chk("accept_timeout", 32'(in_ready[d]), 32'd1);
      in_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid[d] = rnd ? 1'($urandom % 2) : 1'b0;
    a_s[d] = 8'($urandom);
    b_s[d] = 8'($urandom);
    n = 0;
    while (!out_valid[d] && n < 20) begin
      if (rnd) out_ready[d] = 1'($urandom % 2);
      @(posedge clk);
      #1;
      n++;
      if (rnd) begin
        in_valid[d] = 1'($urandom % 2);
        a_s[d] = 8'($urandom);
      end
    end
    chk("out_valid", 32'(out_valid[d]), 32'd1);
    chk("latency", 32'(n), 32'(ecyc));
    chk("product", 32'(prod[d]), 32'(ep));
    for (int i = 0; i < hold; i++) begin
      out_ready[d] = 1'b0;
      in_valid[d] = 1'($urandom % 2);
      a_s[d] = 8'($urandom);
      b_s[d] = 8'($urandom);
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid[d]), 32'd1);
      chk("hold_prod", 32'(prod[d]), 32'(ep));
      chk("hold_in_ready", 32'(in_ready[d]), 32'd0);
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    chk("ret_in_ready", 32'(in_ready[d]), 32'd1);
    chk("ret_out_valid", 32'(out_valid[d]), 32'd0);
    chk("ret_prod_kept", 32'(prod[d]), 32'(ep));
    out_ready[d] = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         d;
    int         hold;
    logic [15:0] prod;
    int         cyc;
  } vec_t;

  vec_t tbl[9];

  initial begin
    n_vec = 0;
    n_err = 0;

    tbl[0] = '{8'hFF, 8'hFF, 0, 0, 16'hFE01, 8};
    tbl[1] = '{8'h00, 8'hAB, 0, 0, 16'h0000, 8};
    tbl[2] = '{8'h37, 8'h00, 0, 0, 16'h0000, 8};
    tbl[3] = '{8'h37, 8'h00, 1, 0, 16'h0000, 1};
    tbl[4] = '{8'h00, 8'hAB, 1, 0, 16'h0000, 8};
    tbl[5] = '{8'h03, 8'h05, 1, 0, 16'h000F, 3};
    tbl[6] = '{8'h03, 8'h80, 1, 0, 16'h0180, 8};
    tbl[7] = '{8'h12, 8'h34, 0, 5, 16'h03A8, 8};
    tbl[8] = '{8'h12, 8'h34, 1, 5, 16'h03A8, 6};

    rst_n = 1'b0;
    in_valid = '0;
    out_ready = '0;
    a_s = '0;
    b_s = '0;
    #3;
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", 32'(in_ready[d]), 32'd1);
      chk("rst_out_valid", 32'(out_valid[d]), 32'd0);
      chk("rst_product", 32'(prod[d]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      chk("tbl_model_prod",
          32'(16'(tbl[i].a) * 16'(tbl[i].b)), 32'(tbl[i].prod));
      chk("tbl_model_cyc",
          32'(run_cycles(tbl[i].d, tbl[i].b)), 32'(tbl[i].cyc));
      run_op(tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].hold, 1'b0);
    end

    // Abort mid-RUN with an asynchronous reset.
    @(negedge clk);
    in_valid[0] = 1'b1;
    a_s[0] = 8'hFF;
    b_s[0] = 8'hFF;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_abort_busy", 32'(in_ready[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready[0]), 32'd1);
    chk("abort_out_valid", 32'(out_valid[0]), 32'd0);
    chk("abort_product", 32'(prod[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 8'h02, 8'h03, 0, 1'b0);

    // Abort while holding a product in DONE.
    @(negedge clk);
    in_valid[1] = 1'b1;
    a_s[1] = 8'h09;
    b_s[1] = 8'h02;
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("done_before_abort", 32'(out_valid[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("done_abort_ov", 32'(out_valid[1]), 32'd0);
    chk("done_abort_prod", 32'(prod[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 1200; k++) begin
        repeat ($urandom % 3) @(negedge clk);
        run_op(d, 8'($urandom), 8'($urandom),
               int'($urandom % 3), 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
